// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants, tx state encoding and width helper
package uart_pkg;

   localparam int PARITY_NONE = 0;
   localparam int PARITY_ODD  = 1;
   localparam int PARITY_EVEN = 2;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } tx_state_e;

   // Bits needed to hold values 0..value-1; never less than 1 so counters stay legal.
   function automatic int clog2(input int value);
      int r;
      int v;
      r = 0;
      v = value - 1;
      while (v > 0) begin
         r = r + 1;
         v = v >> 1;
      end
      return (r < 1) ? 1 : r;
   endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// rtl/uart_baud_tick.sv - bit-period counter with synchronous restart and bit-end tick
module uart_baud_tick
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic clock,
   input  logic rst_n,
   input  logic restart,
   output logic tick
);

   localparam int            CW   = clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q + CW'(1);
      if (restart || (cnt_q == LAST)) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tick = (cnt_q == LAST);

endmodule

// File: rtl/uart_tx_cfg.sv
// rtl/uart_tx_cfg.sv - parametrised UART transmitter with input FIFO
module uart_tx_cfg
   import uart_pkg::*;
#(
   parameter int CLOCK_FREQUENCY = 50000000,
   parameter int BAUD_RATE       = 9600,
   parameter int DATA_BITS       = 8,
   parameter int PARITY          = 0,
   parameter int STOP_BITS       = 1,
   parameter int FIFO_DEPTH      = 4
) (
   input  logic                               clock,
   input  logic                               rst_n,
   input  logic                               tx_valid,
   input  logic [DATA_BITS-1:0]               tx_data_in,
   output logic                               tx_ready,
   output logic                               serial_tx,
   output logic                               tx_busy,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_count
);

   localparam int            CLKS_PER_BIT = CLOCK_FREQUENCY / BAUD_RATE;
   localparam int            AW           = clog2(FIFO_DEPTH);
   localparam int            CW           = $clog2(FIFO_DEPTH + 1);
   localparam int            BW           = clog2(DATA_BITS);
   localparam logic [CW-1:0] DEPTH_C      = CW'(FIFO_DEPTH);
   localparam logic [BW-1:0] BIT_LAST     = BW'(DATA_BITS - 1);
   localparam logic          STOP_LAST    = (STOP_BITS == 2);

   generate
      if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
         $error("uart_tx_cfg: DATA_BITS must be 5..9");
      end
      if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
         $error("uart_tx_cfg: PARITY must be 0, 1 or 2");
      end
      if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
         $error("uart_tx_cfg: STOP_BITS must be 1 or 2");
      end
      if (CLKS_PER_BIT < 2) begin : g_bad_baud
         $error("uart_tx_cfg: CLOCK_FREQUENCY/BAUD_RATE must be >= 2");
      end
      if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
         $error("uart_tx_cfg: FIFO_DEPTH must be a power of two >= 2");
      end
   endgenerate

   logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
   logic [DATA_BITS-1:0] mem_d [FIFO_DEPTH];
   logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]        count_q, count_d;

   tx_state_e            state_q, state_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic [BW-1:0]        bit_q, bit_d;
   logic                 stop_q, stop_d;
   logic                 parity_q, parity_d;
   logic                 serial_q, serial_d;
   logic                 busy_q, busy_d;

   logic                 tick;
   logic                 push;
   logic                 pop;
   logic                 stop_done;
   logic [DATA_BITS-1:0] head;

   uart_baud_tick #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_baud (
      .clock   (clock),
      .rst_n   (rst_n),
      .restart (pop),
      .tick    (tick)
   );

   assign tx_ready   = (count_q != DEPTH_C);
   assign push       = tx_valid && tx_ready;
   assign head       = mem_q[rd_ptr_q];
   assign stop_done  = (state_q == ST_STOP) && tick && (stop_q == STOP_LAST);
   // A pop at the last stop-bit edge chains frames with no idle cycle.
   assign pop        = (count_q != '0) && ((state_q == ST_IDLE) || stop_done);

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      state_d  = state_q;
      shift_d  = shift_q;
      bit_d    = bit_q;
      stop_d   = stop_q;
      parity_d = parity_q;
      serial_d = 1'b1;
      busy_d   = 1'b0;

      if (push) begin
         mem_d[wr_ptr_q] = tx_data_in;
         wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase

      if (pop) begin
         state_d  = ST_START;
         shift_d  = head;
         parity_d = (PARITY == PARITY_ODD) ? ~(^head) : ^head;
      end else if (tick) begin
         case (state_q)
            ST_START: begin
               state_d = ST_DATA;
               bit_d   = '0;
            end
            ST_DATA: begin
               if (bit_q == BIT_LAST) begin
                  state_d = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
                  stop_d  = 1'b0;
               end else begin
                  bit_d   = bit_q + BW'(1);
                  shift_d = shift_q >> 1;
               end
            end
            ST_PARITY: begin
               state_d = ST_STOP;
               stop_d  = 1'b0;
            end
            ST_STOP: begin
               if (stop_q == STOP_LAST) begin
                  state_d = ST_IDLE;
               end else begin
                  stop_d = 1'b1;
               end
            end
            default: state_d = state_q;
         endcase
      end

      // Line level is registered from the next state so serial_tx never glitches.
      case (state_d)
         ST_START:  serial_d = 1'b0;
         ST_DATA:   serial_d = shift_d[0];
         ST_PARITY: serial_d = parity_d;
         default:   serial_d = 1'b1;
      endcase
      busy_d = (state_d != ST_IDLE) || (count_d != '0);
   end

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         state_q  <= ST_IDLE;
         shift_q  <= '0;
         bit_q    <= '0;
         stop_q   <= 1'b0;
         parity_q <= 1'b0;
         serial_q <= 1'b1;
         busy_q   <= 1'b0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         state_q  <= state_d;
         shift_q  <= shift_d;
         bit_q    <= bit_d;
         stop_q   <= stop_d;
         parity_q <= parity_d;
         serial_q <= serial_d;
         busy_q   <= busy_d;
      end
   end

   assign serial_tx  = serial_q;
   assign tx_busy    = busy_q;
   assign fifo_count = count_q;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// tb/tb_uart_tx_cfg.sv - scoreboard bench for uart_tx_cfg across four parameter sets
module tb_uart_tx_cfg;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] vld;
   logic [7:0] din;
   logic [3:0] rdy;
   logic [3:0] ser;
   logic [3:0] busy;
   logic [2:0] cnt [4];

   int         sel;
   int         checks = 0;
   int         errors = 0;
   logic [8:0] exp_q [$];
   logic       in_frame;
   logic       b2b_pending;

   always #5 clk = ~clk;

   // 0: 8N1, 1: 8E1, 2: 8O1, 3: 7N2; all 16 clocks per bit, 4-deep FIFO
   uart_tx_cfg #(.CLOCK_FREQUENCY(16), .BAUD_RATE(1), .DATA_BITS(8), .PARITY(0),
                 .STOP_BITS(1), .FIFO_DEPTH(4)) u_8n1 (
      .clock(clk), .rst_n(rst_n), .tx_valid(vld[0]), .tx_data_in(din),
      .tx_ready(rdy[0]), .serial_tx(ser[0]), .tx_busy(busy[0]), .fifo_count(cnt[0]));
   uart_tx_cfg #(.CLOCK_FREQUENCY(16), .BAUD_RATE(1), .DATA_BITS(8), .PARITY(2),
                 .STOP_BITS(1), .FIFO_DEPTH(4)) u_8e1 (
      .clock(clk), .rst_n(rst_n), .tx_valid(vld[1]), .tx_data_in(din),
      .tx_ready(rdy[1]), .serial_tx(ser[1]), .tx_busy(busy[1]), .fifo_count(cnt[1]));
   uart_tx_cfg #(.CLOCK_FREQUENCY(16), .BAUD_RATE(1), .DATA_BITS(8), .PARITY(1),
                 .STOP_BITS(1), .FIFO_DEPTH(4)) u_8o1 (
      .clock(clk), .rst_n(rst_n), .tx_valid(vld[2]), .tx_data_in(din),
      .tx_ready(rdy[2]), .serial_tx(ser[2]), .tx_busy(busy[2]), .fifo_count(cnt[2]));
   uart_tx_cfg #(.CLOCK_FREQUENCY(16), .BAUD_RATE(1), .DATA_BITS(7), .PARITY(0),
                 .STOP_BITS(2), .FIFO_DEPTH(4)) u_7n2 (
      .clock(clk), .rst_n(rst_n), .tx_valid(vld[3]), .tx_data_in(din[6:0]),
      .tx_ready(rdy[3]), .serial_tx(ser[3]), .tx_busy(busy[3]), .fifo_count(cnt[3]));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   // Entry stores {expected parity bit, word}; parity is ignored for no-parity configs.
   task automatic push_word(input logic [7:0] w, input logic p);
      int n;
      n = 0;
      din = w;
      vld[sel] = 1'b1;
      while (rdy[sel] !== 1'b1 && n < 400) begin
         @(negedge clk);
         n++;
      end
      if (rdy[sel] !== 1'b1) begin
         checks++;
         errors++;
         $display("FAIL push_timeout actual=ready_low required=ready_high word=%h", w);
         vld = '0;
         return;
      end
      @(posedge clk);
      exp_q.push_back({p, w});
      @(negedge clk);
      vld[sel] = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while ((exp_q.size() != 0 || in_frame || b2b_pending || busy[sel] !== 1'b0) && n < 3000) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (n >= 3000) begin
         errors++;
         $display("FAIL idle_timeout actual=busy required=idle sel=%0d", sel);
      end
      check("idle_line", 32'(ser[sel]), 32'd1);
      check("idle_count", 32'(cnt[sel]), 32'd0);
   endtask

   // Monitor: decodes each frame sample by sample and checks every 16-clock bit cell.
   initial begin
      int         bi;
      int         sub;
      int         flen;
      int         db;
      int         pm;
      logic [12:0] fr;
      logic       bad;
      logic       stray;
      logic [8:0] e;
      in_frame    = 1'b0;
      b2b_pending = 1'b0;
      stray       = 1'b0;
      bad         = 1'b0;
      bi = 0; sub = 0; flen = 0; fr = '1; e = '0;
      forever begin
         @(negedge clk);
         if (rst_n !== 1'b1) begin
            in_frame    = 1'b0;
            b2b_pending = 1'b0;
            stray       = 1'b0;
            continue;
         end
         if (b2b_pending) begin
            b2b_pending = 1'b0;
            checks++;
            if (ser[sel] !== 1'b0) begin
               errors++;
               $display("FAIL frame_gap actual=%b required=0 (next start bit)", ser[sel]);
            end
         end
         if (!in_frame && !stray && ser[sel] === 1'b0) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               stray = 1'b1;
               $display("FAIL unexpected_frame actual=start_bit required=idle sel=%0d", sel);
            end else begin
               e    = exp_q.pop_front();
               db   = (sel == 3) ? 7 : 8;
               pm   = (sel == 1 || sel == 2) ? 1 : 0;
               fr   = '1;
               fr[0] = 1'b0;
               for (int i = 0; i < db; i++) fr[1 + i] = e[i];
               if (pm != 0) fr[1 + db] = e[8];
               flen = 1 + db + pm + ((sel == 3) ? 2 : 1);
               in_frame = 1'b1;
               bi = 0; sub = 0; bad = 1'b0;
            end
         end
         if (stray && ser[sel] === 1'b1) stray = 1'b0;
         if (in_frame) begin
            if (ser[sel] !== fr[bi]) bad = 1'b1;
            sub++;
            if (sub == 16) begin
               checks++;
               if (bad) begin
                  errors++;
                  $display("FAIL frame_bit word=%h bit=%0d actual=%b required=%b",
                           e[7:0], bi, ser[sel], fr[bi]);
               end
               sub = 0;
               bad = 1'b0;
               bi++;
               if (bi == flen) begin
                  in_frame    = 1'b0;
                  b2b_pending = (exp_q.size() != 0);
               end
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n;
      rst_n = 1'b0;
      vld   = '0;
      din   = '0;
      sel   = 0;
      repeat (3) @(negedge clk);
      check("reset_serial", 32'(ser[0]), 32'd1);
      check("reset_busy",   32'(busy[0]), 32'd0);
      check("reset_ready",  32'(rdy[0]), 32'd1);
      check("reset_count",  32'(cnt[0]), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // 8N1 single frame: latency and busy window
      push_word(8'hA5, 1'b0);
      check("latency_before_pop", 32'(ser[0]), 32'd1);
      n = 0;
      while (busy[0] === 1'b1 && n < 400) begin
         @(negedge clk);
         n++;
         if (n == 1) check("start_after_pop", 32'(ser[0]), 32'd0);
      end
      check("busy_cycles", 32'(n), 32'd161);
      check("line_after_frame", 32'(ser[0]), 32'd1);
      wait_idle();

      // Even then odd parity, hand-computed parity bits
      sel = 1;
      push_word(8'h55, 1'b0);
      push_word(8'h57, 1'b1);
      wait_idle();
      sel = 2;
      push_word(8'h55, 1'b1);
      push_word(8'h57, 1'b0);
      wait_idle();

      // 7N2
      sel = 3;
      push_word(8'h7F, 1'b0);
      wait_idle();

      // Burst into the FIFO with tx_valid held
      sel = 0;
      push_word(8'h01, 1'b0);
      push_word(8'h02, 1'b0);
      push_word(8'h03, 1'b0);
      push_word(8'h04, 1'b0);
      push_word(8'h05, 1'b0);
      check("full_ready", 32'(rdy[0]), 32'd0);
      check("full_count", 32'(cnt[0]), 32'd4);
      push_word(8'h06, 1'b0);
      wait_idle();

      // Push coincident with the inter-frame pop at fifo_count=1
      push_word(8'h11, 1'b0);
      push_word(8'h22, 1'b0);
      check("pre_boundary_count", 32'(cnt[0]), 32'd1);
      repeat (159) @(negedge clk);
      push_word(8'h33, 1'b0);
      check("boundary_count", 32'(cnt[0]), 32'd1);
      wait_idle();

      // Reset mid-DATA with two words queued
      push_word(8'hC3, 1'b0);
      push_word(8'h44, 1'b0);
      push_word(8'h66, 1'b0);
      check("queued_before_reset", 32'(cnt[0]), 32'd2);
      repeat (40) @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("abort_serial", 32'(ser[0]), 32'd1);
      check("abort_count",  32'(cnt[0]), 32'd0);
      check("abort_ready",  32'(rdy[0]), 32'd1);
      check("abort_busy",   32'(busy[0]), 32'd0);
      exp_q.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      push_word(8'h3C, 1'b0);
      wait_idle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_tx_cfg.md
Name: uart_tx_cfg

Overview:
Parametrised UART transmitter, successor to the fixed 8N1 uart_tx.
- Data width, parity mode, stop-bit count and an input FIFO depth are all parameters.
- Accepts words over a valid/ready handshake, buffers them, and serialises them LSB-first.
- Frames go out back-to-back with no idle gap while the FIFO holds data.
- Sits between the tt_um top-level I/O pins and the serial output pin.

Parameters:
CLOCK_FREQUENCY, 50000000, system clock in Hz
BAUD_RATE, 9600, line rate in baud; CLKS_PER_BIT = CLOCK_FREQUENCY/BAUD_RATE (integer division, 5208 at defaults), must be >= 2
DATA_BITS, 8, data bits per frame, legal range 5..9
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, 1 or 2
FIFO_DEPTH, 4, input FIFO entries, power of two, >= 2

Ports:
clock  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
tx_valid  input  1  tx_data_in is valid this cycle
tx_data_in  input  DATA_BITS  word to transmit
tx_ready  output  1  FIFO can accept a word; high when fifo_count < FIFO_DEPTH
serial_tx  output  1  UART line, idles high
tx_busy  output  1  high while a frame is in flight or the FIFO is non-empty
fifo_count  output  $clog2(FIFO_DEPTH+1)  number of words queued, excluding the word being shifted

Behaviour:
- Reset (rst_n low, asynchronous):
  - serial_tx=1, tx_busy=0, tx_ready=1, fifo_count=0, state=IDLE.
  - FIFO contents, the shift register and the baud counter are discarded.
  - Reset mid-frame aborts the frame immediately; serial_tx goes high without waiting for a clock.
- Push: when tx_valid && tx_ready at a rising edge, the word is written and fifo_count increments.
  - tx_ready is derived from fifo_count only; it does not anticipate a same-cycle pop.
  - tx_valid while tx_ready=0 is ignored; there is no overflow flag.
- Pop: when state is IDLE, or the final stop bit is ending, and fifo_count>0:
  - the head word is loaded into the shift register on that edge;
  - state becomes START and serial_tx=0 (registered);
  - the baud counter restarts at 0.
- Simultaneous push and pop: fifo_count unchanged, and the pointers wrap modulo FIFO_DEPTH.
- Latency: a word accepted into an empty FIFO while IDLE at edge N is popped at edge N+1, so serial_tx falls after edge N+1.
- Baud timing: every state lasts exactly CLKS_PER_BIT cycles. The counter runs 0..CLKS_PER_BIT-1, and a bit-end tick fires at CLKS_PER_BIT-1.
- State machine:
  - IDLE -> START when the FIFO is non-empty.
  - START -> DATA after 1 bit time.
  - DATA -> PARITY after DATA_BITS bits if PARITY != 0, otherwise DATA -> STOP.
  - PARITY -> STOP after 1 bit time.
  - STOP -> START if the FIFO is non-empty at the end of the last stop bit, otherwise STOP -> IDLE.
- Line levels per state: START=0; DATA = shift_reg[0], shifted right each bit; STOP=1; IDLE=1.
- Data bit counter: 0..DATA_BITS-1.
- STOP lasts STOP_BITS bit times, counted with a stop counter.
- Parity bit: even = XOR of the data bits; odd = its inverse. It is computed at load time.
- Frame length in bits: 1 + DATA_BITS + (PARITY!=0) + STOP_BITS.
- tx_busy = (state != IDLE) || (fifo_count != 0), registered-equivalent and glitch-free.
- Illegal parameters (DATA_BITS outside 5..9, PARITY>2, STOP_BITS outside 1..2, CLKS_PER_BIT<2) are caught by elaboration-time checks.

Decomposition:
- Package uart_pkg holds:
  - parity constants PARITY_NONE=0, PARITY_ODD=1, PARITY_EVEN=2;
  - the tx state encoding (IDLE, START, DATA, PARITY, STOP);
  - a clog2 helper for counter widths.
- Sub-module uart_baud_tick: parametrised by CLKS_PER_BIT, with a synchronous restart input and a tick output at the bit end. It is reused later by the receiver.
- The FIFO is inline: a register array plus read/write pointers and a count.

Test Plan:
1. CLOCK_FREQUENCY=16, BAUD_RATE=1, 8N1; push 0xA5 -> serial_tx sequence 0,1,0,1,0,0,1,0,1,1, each bit 16 cycles. tx_busy is high for 161 cycles from the push edge, then serial_tx=1 and tx_busy=0.
2. PARITY=2 (even): push 0x55 -> parity bit 0; push 0x57 -> parity bit 1. Rerun with PARITY=1 (odd) -> parity bits 1 and 0. Frame is 11 bits.
3. DATA_BITS=7, STOP_BITS=2, no parity: push 0x7F -> start 0, seven 1s, stop high for 32 cycles, 10 bits total, then IDLE.
4. FIFO_DEPTH=4: hold tx_valid and push 0x01..0x06 back-to-back. tx_ready drops when fifo_count=4 (after the first word pops). All accepted words are transmitted in order with no idle cycle between frames (stop bit end -> next start bit on the same edge). No word is duplicated or dropped.
5. Push and pop in the same cycle at fifo_count=1 during an inter-frame boundary -> fifo_count stays 1, and both words are transmitted in order.
6. Assert rst_n=0 mid-DATA of 0xC3 with 2 words queued -> serial_tx=1 before the next clock edge, fifo_count=0, tx_ready=1, tx_busy=0. After release, a push of 0x3C transmits a clean, correct frame.
